// File: rtl/imem_loader.sv
// Instruction-memory image loader: parses a big-endian byte stream (16-bit word count, then
// 32-bit words), writes each word to instruction memory and holds the CPU in reset until done.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_direccion,
    output logic [31:0] mem_dato,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;

    logic        byte_ready_q, byte_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_direccion_q, mem_direccion_d;
    logic [31:0] mem_dato_q, mem_dato_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        transfer;

    assign transfer = byte_valid & byte_ready_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned
        // (which would infer a latch); defaults hold state, so gaps change nothing.
        state_d         = state_q;
        count_d         = count_q;
        word_idx_d      = word_idx_q;
        byte_cnt_d      = byte_cnt_q;
        shift_d         = shift_q;
        mem_we_d        = 1'b0;
        mem_direccion_d = mem_direccion_q;
        mem_dato_d      = mem_dato_q;

        case (state_q)
            S_HDR0: begin
                if (transfer) begin
                    count_d = {byte_in, 8'h00};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (transfer) begin
                    count_d = {count_q[15:8], byte_in};
                    if (count_d == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({16'd0, count_d} > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (transfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], byte_in};
                    // Fourth byte completes the word; it is registered so streaming continues.
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d        = 1'b1;
                        mem_dato_d      = {shift_q, byte_in};
                        mem_direccion_d = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        word_idx_d      = word_idx_q + 16'd1;
                        if (word_idx_q == count_q - 16'd1) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_HDR0;
        endcase

        byte_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
        cpu_hold_d   = (state_d != S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_HDR0;
            count_q         <= 16'd0;
            word_idx_q      <= 16'd0;
            byte_cnt_q      <= 2'd0;
            shift_q         <= 24'd0;
            byte_ready_q    <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_direccion_q <= BASE_ADDR;
            mem_dato_q      <= 32'd0;
            cpu_hold_q      <= 1'b1;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            word_idx_q      <= word_idx_d;
            byte_cnt_q      <= byte_cnt_d;
            shift_q         <= shift_d;
            byte_ready_q    <= byte_ready_d;
            mem_we_q        <= mem_we_d;
            mem_direccion_q <= mem_direccion_d;
            mem_dato_q      <= mem_dato_d;
            cpu_hold_q      <= cpu_hold_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

    assign byte_ready    = byte_ready_q;
    assign mem_we        = mem_we_q;
    assign mem_direccion = mem_direccion_q;
    assign mem_dato      = mem_dato_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0x00400000) share one byte stream;
// writes are compared against an image-level model of the expected memory contents.
module tb_imem_loader;

    localparam int unsigned DEPTH = 64;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        hold;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        o_ready[2];
    logic        o_we[2];
    logic [31:0] o_dir[2];
    logic [31:0] o_dato[2];
    logic        o_hold[2];
    logic        o_done[2];
    logic        o_err[2];

    wr_t obs[2][$];
    wr_t exp_wr[2][$];
    logic exp_err;
    logic prev_we[2] = '{1'b0, 1'b0};
    int   b2b = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(o_ready[0]), .mem_we(o_we[0]), .mem_direccion(o_dir[0]),
        .mem_dato(o_dato[0]), .cpu_hold(o_hold[0]), .done(o_done[0]), .error(o_err[0])
    );

    imem_loader #(.BASE_ADDR(32'h0040_0000), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(o_ready[1]), .mem_we(o_we[1]), .mem_direccion(o_dir[1]),
        .mem_dato(o_dato[1]), .cpu_hold(o_hold[1]), .done(o_done[1]), .error(o_err[1])
    );

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'h0040_0000;
    endfunction

    // Capture every write strobe and flag any strobe held for two consecutive cycles.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_we[k]) begin
                obs[k].push_back('{o_dir[k], o_dato[k], o_done[k], o_hold[k]});
                if (prev_we[k]) b2b++;
            end
            prev_we[k] <= o_we[k];
        end
    end

    task automatic check(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Image model: header count, then word i lands at base + 4*i; last word carries done.
    task automatic build_expected(input byte_q_t b);
        int unsigned cnt;
        logic [31:0] w;
        logic        last;
        cnt = {b[0], b[1]};
        exp_err = (cnt > DEPTH);
        for (int k = 0; k < 2; k++) begin
            exp_wr[k].delete();
            if (!exp_err) begin
                for (int i = 0; i < int'(cnt); i++) begin
                    w    = {b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]};
                    last = (i == int'(cnt) - 1);
                    exp_wr[k].push_back('{base_of(k) + 32'(4 * i), w, last, !last});
                end
            end
        end
    endtask

    function automatic byte_q_t make_stream(input logic [15:0] cnt, input int nwords);
        byte_q_t q;
        q.push_back(cnt[15:8]);
        q.push_back(cnt[7:0]);
        for (int i = 0; i < 4 * nwords; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_rst_ready%0d", tag, k), o_ready[k], 1'b0);
            check($sformatf("%s_rst_we%0d", tag, k), o_we[k], 1'b0);
            check($sformatf("%s_rst_dir%0d", tag, k), o_dir[k], base_of(k));
            check($sformatf("%s_rst_dato%0d", tag, k), o_dato[k], 32'd0);
            check($sformatf("%s_rst_flags%0d", tag, k), {o_hold[k], o_done[k], o_err[k]}, 3'b100);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic do_reset(input string tag);
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        @(negedge clk);
        check_reset_values(tag);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) obs[k].delete();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check($sformatf("%s_ready_after_rst%0d", tag, k), o_ready[k], 1'b1);
    endtask

    // Handshaked send of b[first..last-1] with random 0..max_gap idle cycles before each byte.
    task automatic send(input string tag, input byte_q_t b, input int first, input int last,
                        input int max_gap);
        int guard;
        for (int i = first; i < last; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                @(negedge clk);
            end
            byte_valid = 1'b1;
            byte_in    = b[i];
            guard      = 0;
            while (!o_ready[0] && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 40) check($sformatf("%s_ready_timeout", tag), 1'b1, 1'b0);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_blind(input int n);
        repeat (n) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic compare(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_nwr%0d", tag, k), obs[k].size(), exp_wr[k].size());
            for (int i = 0; i < obs[k].size() && i < exp_wr[k].size(); i++) begin
                check($sformatf("%s_wr%0d_%0d", tag, k, i),
                      {obs[k][i].addr, obs[k][i].data}, {exp_wr[k][i].addr, exp_wr[k][i].data});
                check($sformatf("%s_wrflags%0d_%0d", tag, k, i),
                      {obs[k][i].done, obs[k][i].hold}, {exp_wr[k][i].done, exp_wr[k][i].hold});
            end
            check($sformatf("%s_final%0d", tag, k),
                  {o_done[k], o_err[k], o_hold[k], o_ready[k]}, {!exp_err, exp_err, exp_err, 1'b0});
        end
    endtask

    task automatic run_case(input string tag, input byte_q_t b, input int max_gap);
        int unsigned cnt;
        int nacc;
        do_reset(tag);
        build_expected(b);
        cnt  = {b[0], b[1]};
        nacc = (exp_err || cnt == 0) ? 2 : 2 + 4 * int'(cnt);
        send(tag, b, 0, nacc, max_gap);
        if (exp_err || cnt == 0) begin
            for (int k = 0; k < 2; k++)
                check($sformatf("%s_hdr_next%0d", tag, k),
                      {o_done[k], o_err[k], o_hold[k], o_ready[k]}, {!exp_err, exp_err, exp_err, 1'b0});
        end
        send_blind(8);
        repeat (3) @(negedge clk);
        compare(tag);
    endtask

    initial begin
        byte_q_t t1, t6, s;
        t1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        t6 = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11,
               8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33};
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        @(negedge clk);

        run_case("t1_full_rate", t1, 0);
        run_case("t2_zero_count", '{8'h00, 8'h00}, 0);
        run_case("t3_over_depth", '{8'h00, 8'h41}, 0);
        run_case("t4_gaps_a", t1, 3);
        run_case("t4_gaps_b", t1, 3);

        // Reset right after 0x8C is accepted: first word written, second one partial.
        do_reset("t5_pre");
        build_expected(t1);
        send("t5_prefix", t1, 0, 7, 0);
        check("t5_prefix_nwr", obs[0].size(), 1);
        if (obs[0].size() > 0)
            check("t5_prefix_wr0", {obs[0][0].addr, obs[0][0].data},
                  {exp_wr[0][0].addr, exp_wr[0][0].data});
        check("t5_prefix_hold", {o_hold[0], o_done[0]}, 2'b10);
        do_reset("t5_mid");
        run_case("t5_resend", t1, 0);

        run_case("t6_three_words", t6, 0);
        run_case("depth_exact", make_stream(16'd64, 64), 0);
        run_case("count_ffff", make_stream(16'hFFFF, 0), 0);
        for (int r = 0; r < 5; r++) begin
            int unsigned n;
            n = $urandom_range(1, 6);
            s = make_stream(16'(n), int'(n));
            run_case($sformatf("rand%0d", r), s, $urandom_range(0, 2));
        end

        check("no_back_to_back_we", b2b, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
